// File: rtl/mem_ctrl_pkg.sv
// Shared types, constants and helpers for the memory controller.
package mem_ctrl_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] word_t;
  typedef logic [7:0]  byte_t;

  localparam word_t ZERO_WORD = 32'h0000_0000;

  // Access size field encodes "bytes minus one".
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd3;

  // Default base of the memory-mapped IO window.
  localparam addr_t IO_BASE_DEFAULT = 32'h0003_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_IF_READ,
    ST_LSU_READ,
    ST_LSU_WRITE
  } state_t;

  // Number of bytes moved for a given size code.
  function automatic logic [2:0] size_to_len(input logic [1:0] size);
    return {1'b0, size} + 3'd1;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Memory controller: serialises instruction-fetch and load/store requests
// into byte accesses on an 8-bit RAM bus.
//
// Handshake: requests are one-cycle pulses sampled on an edge with rdy high;
// each port accepts a new pulse only when it has nothing pending or in flight
// (otherwise the pulse is dropped). Completion is a one-cycle result pulse,
// with the data output holding until the next completion on that port.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter addr_t IO_BASE = IO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear_flag_in,
  input  logic        if_fetch_enable_in,
  input  logic [31:0] if_addr_in,
  output logic        if_result_enable_out,
  output logic [31:0] if_data_out,
  input  logic        lsu_enable_in,
  input  logic        lsu_wr_in,
  input  logic [1:0]  lsu_size_in,
  input  logic [31:0] lsu_addr_in,
  input  logic [31:0] lsu_data_in,
  output logic        lsu_result_enable_out,
  output logic [31:0] lsu_data_out,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  state_t     state;

  // Latched requests.
  logic       if_pend;
  logic       lsu_pend;
  addr_t      if_addr_q;
  addr_t      lsu_addr_q;
  logic       lsu_wr_q;
  logic [1:0] lsu_size_q;
  word_t      lsu_data_q;

  // Byte engine: issue_cnt counts addresses put on the bus, cap_cnt counts
  // bytes captured. addr_live/data_live track a read address through the
  // two-edge RAM latency so only genuinely requested bytes are captured.
  logic [2:0] issue_cnt;
  logic [2:0] cap_cnt;
  logic       addr_live;
  logic       data_live;
  word_t      asm_q;

  logic       if_busy;
  logic       lsu_busy;
  logic       if_req;
  logic       lsu_req;
  logic       lsu_go;
  logic       if_go;
  addr_t      if_start_addr;
  addr_t      lsu_start_addr;
  logic       go_wr;
  word_t      go_data;
  logic       go_stall;
  addr_t      cur_base;
  logic [2:0] cur_len;
  logic       cur_stall;
  byte_t      wr_byte;
  word_t      asm_next;

  function automatic logic is_io(input addr_t a);
    return (a == IO_BASE) || (a == IO_BASE + 32'd4);
  endfunction

  // Request acceptance, arbitration and datapath selects.
  always_comb begin
    if_busy        = if_pend || (state == ST_IF_READ);
    lsu_busy       = lsu_pend || (state == ST_LSU_READ) || (state == ST_LSU_WRITE);
    if_req         = rdy && if_fetch_enable_in && !if_busy && !clear_flag_in;
    lsu_req        = rdy && lsu_enable_in && !lsu_busy;
    lsu_go         = (state == ST_IDLE) && rdy && (lsu_pend || lsu_req);
    if_go          = (state == ST_IDLE) && rdy && !lsu_go && !clear_flag_in &&
                     (if_pend || if_req);
    if_start_addr  = if_pend  ? if_addr_q  : if_addr_in;
    lsu_start_addr = lsu_pend ? lsu_addr_q : lsu_addr_in;
    go_wr          = lsu_pend ? lsu_wr_q   : lsu_wr_in;
    go_data        = lsu_pend ? lsu_data_q : lsu_data_in;
    go_stall       = io_buffer_full && is_io(lsu_start_addr);
    cur_base       = (state == ST_IF_READ) ? if_addr_q : lsu_addr_q;
    cur_len        = (state == ST_IF_READ) ? size_to_len(SIZE_WORD)
                                           : size_to_len(lsu_size_q);
    cur_stall      = io_buffer_full && is_io(lsu_addr_q);
    wr_byte        = lsu_data_q[{issue_cnt[1:0], 3'b000} +: 8];
    asm_next       = asm_q;
    asm_next[{cap_cnt[1:0], 3'b000} +: 8] = mem_din;
  end

  // Latch incoming requests and maintain the per-port pending flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_pend    <= 1'b0;
      lsu_pend   <= 1'b0;
      if_addr_q  <= ZERO_WORD;
      lsu_addr_q <= ZERO_WORD;
      lsu_wr_q   <= 1'b0;
      lsu_size_q <= SIZE_BYTE;
      lsu_data_q <= ZERO_WORD;
    end else begin
      if (if_req) if_addr_q <= if_addr_in;
      if (lsu_req) begin
        lsu_addr_q <= lsu_addr_in;
        lsu_wr_q   <= lsu_wr_in;
        lsu_size_q <= lsu_size_in;
        lsu_data_q <= lsu_data_in;
      end
      if (clear_flag_in || if_go) if_pend <= 1'b0;
      else if (if_req)            if_pend <= 1'b1;
      if (lsu_go)       lsu_pend <= 1'b0;
      else if (lsu_req) lsu_pend <= 1'b1;
    end
  end

  // Main FSM: drives the RAM bus and registers the result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= ST_IDLE;
      mem_a                 <= ZERO_WORD;
      mem_dout              <= 8'h00;
      mem_wr                <= 1'b0;
      if_result_enable_out  <= 1'b0;
      if_data_out           <= ZERO_WORD;
      lsu_result_enable_out <= 1'b0;
      lsu_data_out          <= ZERO_WORD;
      issue_cnt             <= 3'd0;
      cap_cnt               <= 3'd0;
      addr_live             <= 1'b0;
      data_live             <= 1'b0;
      asm_q                 <= ZERO_WORD;
    end else begin
      if_result_enable_out  <= 1'b0;
      lsu_result_enable_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          mem_wr    <= 1'b0;
          addr_live <= 1'b0;
          data_live <= 1'b0;
          cap_cnt   <= 3'd0;
          asm_q     <= ZERO_WORD;
          if (lsu_go) begin
            mem_a <= lsu_start_addr;
            if (go_wr) begin
              state <= ST_LSU_WRITE;
              if (go_stall) begin
                issue_cnt <= 3'd0;
              end else begin
                mem_wr    <= 1'b1;
                mem_dout  <= go_data[7:0];
                issue_cnt <= 3'd1;
              end
            end else begin
              state     <= ST_LSU_READ;
              issue_cnt <= 3'd1;
              addr_live <= 1'b1;
            end
          end else if (if_go) begin
            state     <= ST_IF_READ;
            mem_a     <= if_start_addr;
            issue_cnt <= 3'd1;
            addr_live <= 1'b1;
          end
        end

        ST_IF_READ, ST_LSU_READ: begin
          if ((state == ST_IF_READ) && clear_flag_in) begin
            state     <= ST_IDLE;
            mem_a     <= ZERO_WORD;
            addr_live <= 1'b0;
            data_live <= 1'b0;
          end else if (!rdy) begin
            // Bytes in the RAM pipeline are unreliable across a stall:
            // rewind issue to the next byte still to be captured.
            mem_wr    <= 1'b0;
            mem_a     <= cur_base + {29'd0, cap_cnt};
            issue_cnt <= cap_cnt;
            addr_live <= 1'b0;
            data_live <= 1'b0;
          end else begin
            data_live <= addr_live;
            addr_live <= (issue_cnt < cur_len);
            if (issue_cnt < cur_len) begin
              mem_a     <= cur_base + {29'd0, issue_cnt};
              issue_cnt <= issue_cnt + 3'd1;
            end
            if (data_live) begin
              asm_q   <= asm_next;
              cap_cnt <= cap_cnt + 3'd1;
              if (cap_cnt == cur_len - 3'd1) begin
                state     <= ST_IDLE;
                mem_a     <= ZERO_WORD;
                addr_live <= 1'b0;
                data_live <= 1'b0;
                if (state == ST_IF_READ) begin
                  if_result_enable_out <= 1'b1;
                  if_data_out          <= asm_next;
                end else begin
                  lsu_result_enable_out <= 1'b1;
                  lsu_data_out          <= asm_next;
                end
              end
            end
          end
        end

        ST_LSU_WRITE: begin
          if (!rdy) begin
            mem_wr <= 1'b0;
          end else if (issue_cnt == cur_len) begin
            mem_wr                <= 1'b0;
            mem_a                 <= ZERO_WORD;
            lsu_result_enable_out <= 1'b1;
            state                 <= ST_IDLE;
          end else if (cur_stall) begin
            mem_wr <= 1'b0;
          end else begin
            mem_wr    <= 1'b1;
            mem_a     <= lsu_addr_q + {29'd0, issue_cnt};
            mem_dout  <= wr_byte;
            issue_cnt <= issue_cnt + 3'd1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte RAM model, result scoreboard,
// table of load/store vectors and hand-written multi-cycle sequences.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        clear_flag_in = 1'b0;
  logic        if_fetch_enable_in = 1'b0;
  logic [31:0] if_addr_in = 32'h0;
  logic        if_result_enable_out;
  logic [31:0] if_data_out;
  logic        lsu_enable_in = 1'b0;
  logic        lsu_wr_in = 1'b0;
  logic [1:0]  lsu_size_in = 2'd0;
  logic [31:0] lsu_addr_in = 32'h0;
  logic [31:0] lsu_data_in = 32'h0;
  logic        lsu_result_enable_out;
  logic [31:0] lsu_data_out;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear_flag_in(clear_flag_in),
    .if_fetch_enable_in(if_fetch_enable_in), .if_addr_in(if_addr_in),
    .if_result_enable_out(if_result_enable_out), .if_data_out(if_data_out),
    .lsu_enable_in(lsu_enable_in), .lsu_wr_in(lsu_wr_in),
    .lsu_size_in(lsu_size_in), .lsu_addr_in(lsu_addr_in),
    .lsu_data_in(lsu_data_in), .lsu_result_enable_out(lsu_result_enable_out),
    .lsu_data_out(lsu_data_out), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  // ---------------- counters / scoreboard ----------------
  int checks = 0;
  int passed = 0;
  logic [31:0] if_exp_q[$];
  logic [32:0] lsu_exp_q[$];   // {compare_data, expected_data}
  logic [7:0]  ram [0:8191];
  int          wr_cycles = 0;
  int          io_writes = 0;
  logic [7:0]  io_last = 8'h00;
  int          if_pulses = 0;
  int          lsu_pulses = 0;
  logic        prev_if = 1'b0;
  logic        prev_lsu = 1'b0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b, required %b", name, act, exp);
  endtask

  // Byte RAM: read data appears the cycle after the address is sampled.
  always @(posedge clk) begin
    if (mem_wr) begin
      wr_cycles++;
      if (mem_a < 32'd8192) ram[mem_a[12:0]] = mem_dout;
      if (mem_a == 32'h0003_0000) begin
        io_writes++;
        io_last = mem_dout;
      end
    end
    mem_din <= (mem_a < 32'd8192) ? ram[mem_a[12:0]] : 8'h00;
  end

  // Result monitor: pops the scoreboard whenever a result pulse is seen.
  always @(negedge clk) begin
    if (!rst) begin
      if (if_result_enable_out) begin
        if_pulses++;
        check1("if_pulse_width", prev_if, 1'b0);
        if (if_exp_q.size() == 0) begin
          checks++;
          $display("FAIL if_unexpected_result: got pulse with data 0x%08h, required no pulse", if_data_out);
        end else begin
          check32("if_data", if_data_out, if_exp_q.pop_front());
        end
      end
      if (lsu_result_enable_out) begin
        lsu_pulses++;
        check1("lsu_pulse_width", prev_lsu, 1'b0);
        if (lsu_exp_q.size() == 0) begin
          checks++;
          $display("FAIL lsu_unexpected_result: got pulse with data 0x%08h, required no pulse", lsu_data_out);
        end else begin
          logic [32:0] e;
          e = lsu_exp_q.pop_front();
          if (e[32]) check32("lsu_data", lsu_data_out, e[31:0]);
        end
      end
      prev_if  = if_result_enable_out;
      prev_lsu = lsu_result_enable_out;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic lsu_op(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] exp_data, input int exp_lat);
    int lat;
    @(negedge clk);
    lsu_enable_in = 1'b1;
    lsu_wr_in     = wr;
    lsu_size_in   = size;
    lsu_addr_in   = addr;
    lsu_data_in   = data;
    lsu_exp_q.push_back({!wr, exp_data});
    @(posedge clk);
    #1 lsu_enable_in = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (lsu_result_enable_out) begin
        lat = k;
        break;
      end
    end
    check32("lsu_latency", lat, exp_lat);
  endtask

  task automatic if_fetch(input logic [31:0] addr, input logic [31:0] exp_data, input int exp_lat);
    int lat;
    @(negedge clk);
    if_fetch_enable_in = 1'b1;
    if_addr_in         = addr;
    if_exp_q.push_back(exp_data);
    @(posedge clk);
    #1 if_fetch_enable_in = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (if_result_enable_out) begin
        lat = k;
        break;
      end
    end
    check32("if_latency", lat, exp_lat);
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs[10];

  // ---------------- test sequence ----------------
  initial begin
    int w0;
    int p0;
    int lsu_lat;
    int if_lat;

    vecs[0] = '{1'b1, 2'd1, 32'h0000_0101, 32'h0000_BEEF, 32'h0, 2};
    vecs[1] = '{1'b0, 2'd0, 32'h0000_0102, 32'h0, 32'h0000_00BE, 2};
    vecs[2] = '{1'b0, 2'd0, 32'h0000_0101, 32'h0, 32'h0000_00EF, 2};
    vecs[3] = '{1'b1, 2'd3, 32'h0000_0200, 32'hCAFE_F00D, 32'h0, 4};
    vecs[4] = '{1'b0, 2'd3, 32'h0000_0200, 32'h0, 32'hCAFE_F00D, 5};
    vecs[5] = '{1'b0, 2'd1, 32'h0000_0202, 32'h0, 32'h0000_CAFE, 3};
    vecs[6] = '{1'b1, 2'd0, 32'h0000_0203, 32'h1234_565A, 32'h0, 1};
    vecs[7] = '{1'b0, 2'd3, 32'h0000_0200, 32'h0, 32'h5AFE_F00D, 5};
    vecs[8] = '{1'b0, 2'd1, 32'h0000_0100, 32'h0, 32'h0000_EF77, 3};
    vecs[9] = '{1'b0, 2'd3, 32'h0000_0101, 32'h0, 32'h0000_BEEF, 5};

    for (int i = 0; i < 8192; i++) ram[i] = 8'h00;
    ram[13'h1000] = 8'h13; ram[13'h1001] = 8'h05;
    ram[13'h0020] = 8'h78; ram[13'h0021] = 8'h56; ram[13'h0022] = 8'h34; ram[13'h0023] = 8'h12;
    ram[13'h0000] = 8'h11; ram[13'h0001] = 8'h22; ram[13'h0002] = 8'h33; ram[13'h0003] = 8'h44;
    ram[13'h0100] = 8'h77;
    ram[13'h0040] = 8'hA1; ram[13'h0041] = 8'hB2; ram[13'h0042] = 8'hC3; ram[13'h0043] = 8'hD4;

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check1 ("rst_if_pulse",  if_result_enable_out, 1'b0);
    check1 ("rst_lsu_pulse", lsu_result_enable_out, 1'b0);
    check1 ("rst_mem_wr",    mem_wr, 1'b0);
    check32("rst_mem_a",     mem_a, 32'h0);
    check32("rst_mem_dout",  {24'h0, mem_dout}, 32'h0);
    check32("rst_if_data",   if_data_out, 32'h0);
    check32("rst_lsu_data",  lsu_data_out, 32'h0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Basic instruction fetch
    w0 = wr_cycles;
    if_fetch(32'h0000_1000, 32'h0000_0513, 5);
    check32("fetch_no_writes", wr_cycles - w0, 0);

    // Simultaneous LSU and IF requests: LSU first
    @(negedge clk);
    lsu_enable_in = 1'b1; lsu_wr_in = 1'b0; lsu_size_in = 2'd3; lsu_addr_in = 32'h20;
    if_fetch_enable_in = 1'b1; if_addr_in = 32'h0;
    lsu_exp_q.push_back({1'b1, 32'h1234_5678});
    if_exp_q.push_back(32'h4433_2211);
    @(posedge clk);
    #1;
    lsu_enable_in = 1'b0;
    if_fetch_enable_in = 1'b0;
    lsu_lat = -1;
    if_lat  = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (lsu_result_enable_out && lsu_lat < 0) lsu_lat = k;
      if (if_result_enable_out && if_lat < 0) if_lat = k;
    end
    check32("arb_lsu_latency", lsu_lat, 5);
    check1 ("arb_if_after_lsu", (if_lat > lsu_lat), 1'b1);

    // Table of loads and stores
    for (int i = 0; i < 10; i++)
      lsu_op(vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].data, vecs[i].exp_data, vecs[i].exp_lat);

    // Flush mid fetch
    p0 = if_pulses;
    @(negedge clk);
    if_fetch_enable_in = 1'b1; if_addr_in = 32'h100;
    @(posedge clk);
    #1 if_fetch_enable_in = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    clear_flag_in = 1'b1;
    @(posedge clk);
    #1 clear_flag_in = 1'b0;
    check32("clear_mem_a", mem_a, 32'h0);
    repeat (8) @(posedge clk);
    #1 check32("clear_no_result", if_pulses - p0, 0);

    // Flush on the same edge as a fetch request drops it
    @(negedge clk);
    if_fetch_enable_in = 1'b1; if_addr_in = 32'h0; clear_flag_in = 1'b1;
    @(posedge clk);
    #1;
    if_fetch_enable_in = 1'b0;
    clear_flag_in = 1'b0;
    repeat (8) @(posedge clk);
    #1 check32("clear_same_edge_dropped", if_pulses - p0, 0);

    if_fetch(32'h0000_0200, 32'h5AFE_F00D, 5);

    // IO write stalled by a full buffer
    w0 = io_writes;
    @(negedge clk);
    io_buffer_full = 1'b1;
    lsu_enable_in = 1'b1; lsu_wr_in = 1'b1; lsu_size_in = 2'd0;
    lsu_addr_in = 32'h0003_0000; lsu_data_in = 32'h0000_0041;
    lsu_exp_q.push_back({1'b0, 32'h0});
    @(posedge clk);
    #1 lsu_enable_in = 1'b0;
    check1("io_stall_wr_e0", mem_wr, 1'b0);
    @(posedge clk);
    #1 check1("io_stall_wr_e1", mem_wr, 1'b0);
    @(posedge clk);
    #1 check1("io_stall_wr_e2", mem_wr, 1'b0);
    io_buffer_full = 1'b0;
    @(posedge clk);
    #1;
    check1 ("io_write_wr",   mem_wr, 1'b1);
    check32("io_write_addr", mem_a, 32'h0003_0000);
    check32("io_write_data", {24'h0, mem_dout}, 32'h41);
    @(posedge clk);
    #1;
    check1("io_done_pulse", lsu_result_enable_out, 1'b1);
    check1("io_done_wr",    mem_wr, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check32("io_write_count", io_writes - w0, 1);
    check32("io_write_byte",  {24'h0, io_last}, 32'h41);

    // rdy low during a word fetch
    w0 = wr_cycles;
    p0 = if_pulses;
    @(negedge clk);
    if_fetch_enable_in = 1'b1; if_addr_in = 32'h40;
    if_exp_q.push_back(32'hD4C3_B2A1);
    @(posedge clk);
    #1 if_fetch_enable_in = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rdy = 1'b0;
    @(posedge clk);
    #1;
    check1 ("stall_wr_e3",  mem_wr, 1'b0);
    check32("stall_mem_a",  mem_a, 32'h41);
    @(posedge clk);
    #1;
    check1("stall_wr_e4", mem_wr, 1'b0);
    rdy = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check32("stall_single_result", if_pulses - p0, 1);
    check32("stall_no_writes", wr_cycles - w0, 0);

    // Drain
    repeat (5) @(posedge clk);
    #1;
    check32("if_queue_empty",  if_exp_q.size(), 0);
    check32("lsu_queue_empty", lsu_exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
